// File: rtl/crank_wheel_gen.sv
// Missing-tooth crank trigger-wheel generator: one tooth slot per programmed
// period, with tooth index and a once-per-revolution sync pulse.
module crank_wheel_gen #(
  parameter int PCNT_WIDTH    = 24,
  parameter int TCNT_WIDTH    = 6,
  parameter int TEETH_TOTAL   = 60,
  parameter int TEETH_MISSING = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ena,
  input  logic [PCNT_WIDTH-1:0] period,
  output logic                  cap_out,
  output logic [TCNT_WIDTH-1:0] tooth_out,
  output logic                  rev,
  output logic                  busy
);

  localparam logic [TCNT_WIDTH-1:0] LAST_TOOTH = TCNT_WIDTH'(TEETH_TOTAL - 1);
  localparam logic [TCNT_WIDTH-1:0] FIRST_GAP  = TCNT_WIDTH'(TEETH_TOTAL - TEETH_MISSING);

  typedef enum logic [1:0] {IDLE, HIGH, LOW, GAP} state_t;

  state_t                state;
  logic [PCNT_WIDTH-1:0] pcnt;
  logic [PCNT_WIDTH-1:0] p_q;
  logic [PCNT_WIDTH-1:0] period_clamped;
  logic [PCNT_WIDTH-1:0] high_last;
  logic [PCNT_WIDTH-1:0] slot_last;
  logic [TCNT_WIDTH-1:0] next_tooth;

  // Periods below 2 would leave no room for both a high and a low phase.
  always_comb begin
    period_clamped = (period < PCNT_WIDTH'(2)) ? PCNT_WIDTH'(2) : period;
    high_last      = (p_q >> 1) - PCNT_WIDTH'(1);
    slot_last      = p_q - PCNT_WIDTH'(1);
    next_tooth     = (tooth_out == LAST_TOOTH) ? '0 : tooth_out + TCNT_WIDTH'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      pcnt      <= '0;
      p_q       <= PCNT_WIDTH'(2);
      cap_out   <= 1'b0;
      tooth_out <= '0;
      rev       <= 1'b0;
      busy      <= 1'b0;
    end else begin
      rev <= 1'b0;
      case (state)
        IDLE: begin
          if (ena) begin
            state     <= HIGH;
            tooth_out <= '0;
            pcnt      <= '0;
            p_q       <= period_clamped;
            cap_out   <= 1'b1;
            rev       <= 1'b1;
            busy      <= 1'b1;
          end
        end
        HIGH: begin
          pcnt <= pcnt + PCNT_WIDTH'(1);
          if (pcnt == high_last) begin
            state   <= LOW;
            cap_out <= 1'b0;
          end
        end
        LOW, GAP: begin
          if (pcnt != slot_last) begin
            pcnt <= pcnt + PCNT_WIDTH'(1);
          end else if (!ena) begin
            // tooth_out is deliberately held so the stopping slot stays visible.
            state   <= IDLE;
            pcnt    <= '0;
            cap_out <= 1'b0;
            busy    <= 1'b0;
          end else begin
            pcnt      <= '0;
            p_q       <= period_clamped;
            tooth_out <= next_tooth;
            if (next_tooth == '0) begin
              state   <= HIGH;
              cap_out <= 1'b1;
              rev     <= 1'b1;
            end else if (next_tooth >= FIRST_GAP) begin
              state   <= GAP;
              cap_out <= 1'b0;
            end else begin
              state   <= HIGH;
              cap_out <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
